dwc_recovery_ctrl: RTL and testbench



---
 rtl/dwc_pkg.sv | 23 ++
 rtl/dwc_sat_counter.sv | 23 ++
 rtl/dwc_recovery_ctrl.sv | 136 +++++++++++++
 tb/tb_dwc_recovery_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dwc_pkg.sv
// Shared types and defaults for the DwC recovery controller: FSM state encoding,
// default parameter values and the retry-counter width helper.
package dwc_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_REPLAY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FAULT  = 3'd4
  } dwc_state_e;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_MAX_RETRY = 3;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_TIMEOUT   = 16;

  // Retry counter must hold 0..max_retry inclusive.
  function automatic int retry_width(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/dwc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear is applied before increment,
// so clr+inc in one cycle yields 1. One-cycle update latency, no backpressure.
module dwc_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dwc_recovery_ctrl.sv
// Stalls and replays on a qualified DwC mismatch, faults after MAX_RETRY failed replays; outputs registered,
// stall lands one cycle after the mismatch edge. Optional CHECK watchdog under DWC_TIMEOUT_EN.
module dwc_recovery_ctrl
  import dwc_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
`ifdef DWC_TIMEOUT_EN
  parameter int TIMEOUT   = DEF_TIMEOUT,
`endif
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              port_clk,
  input  logic              port_rst_n,
  input  logic [NUM_CH-1:0] port_dwc_ok,
  input  logic              port_valid,
  input  logic              port_clear,
  output logic              port_stall,
  output logic              port_replay,
  output logic              port_fault,
  output logic [NUM_CH-1:0] port_syndrome,
  output logic [CNT_W-1:0]  port_err_count
);

  localparam int RW = retry_width(MAX_RETRY);

  dwc_state_e    state;
  logic [RW-1:0] retry;
  logic          mismatch;
  logic          accept_mm;

  assign mismatch  = port_valid && !(&port_dwc_ok);
  // Only RUN and CHECK look at the compare lines; STALL/REPLAY/FAULT ignore them.
  assign accept_mm = mismatch && ((state == ST_RUN) || (state == ST_CHECK));

`ifdef DWC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_expire;

  assign wd_expire = (state == ST_CHECK) && !port_valid && (wd_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      wd_cnt <= '0;
    end else if ((state == ST_CHECK) && !port_valid) begin
      wd_cnt <= wd_cnt + TW'(1);
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

  dwc_sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (port_clk),
    .rst_n (port_rst_n),
    .clr   (port_clear),
    .inc   (accept_mm),
    .count (port_err_count)
  );

  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      state         <= ST_RUN;
      retry         <= '0;
      port_stall    <= 1'b0;
      port_replay   <= 1'b0;
      port_fault    <= 1'b0;
      port_syndrome <= '0;
    end else begin
      port_replay <= 1'b0;

      if (accept_mm) begin
        port_syndrome <= (port_clear ? '0 : port_syndrome) | ~port_dwc_ok;
      end else if (port_clear) begin
        port_syndrome <= '0;
      end

      case (state)
        ST_RUN: begin
          if (mismatch) begin
            state      <= ST_STALL;
            retry      <= RW'(1);
            port_stall <= 1'b1;
          end
        end
        ST_STALL: begin
          state       <= ST_REPLAY;
          port_replay <= 1'b1;
        end
        ST_REPLAY: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (retry == RW'(MAX_RETRY)) begin
              state      <= ST_FAULT;
              port_fault <= 1'b1;
            end else begin
              state <= ST_STALL;
              retry <= retry + RW'(1);
            end
          end else if (port_valid) begin
            state      <= ST_RUN;
            retry      <= '0;
            port_stall <= 1'b0;
          end
`ifdef DWC_TIMEOUT_EN
          else if (wd_expire) begin
            state         <= ST_FAULT;
            port_fault    <= 1'b1;
            port_syndrome <= '1;
          end
`endif
        end
        ST_FAULT: begin
          if (port_clear) begin
            state      <= ST_RUN;
            retry      <= '0;
            port_stall <= 1'b0;
            port_fault <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          retry      <= '0;
          port_stall <= 1'b0;
          port_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dwc_recovery_ctrl.sv
// Bench for dwc_recovery_ctrl: directed scenarios plus random traffic against a schedule-based model,
// with a second CNT_W=2 instance sharing the stimulus to exercise saturation.
module tb_dwc_recovery_ctrl;

  localparam int NCH  = 4;
  localparam int MAXR = 3;
  localparam int TMO  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] dwc_ok = '1;
  logic           valid = 1'b0;
  logic           clear = 1'b0;

  logic           stall, replay, fault;
  logic [NCH-1:0] syndrome;
  logic [7:0]     err_count;
  logic           s_stall, s_replay, s_fault;
  logic [NCH-1:0] s_syndrome;
  logic [1:0]     s_err_count;

  int errors = 0;
  int checks = 0;

  // Model: an episode schedule rather than a state machine. m_cd counts the
  // stall/replay cycles still owed, m_wait marks the recheck window.
  bit m_fault, m_wait;
  int m_cd, m_att, m_cnt, m_w;
  logic [NCH-1:0] m_syn;

  always #5 clk = ~clk;

  dwc_recovery_ctrl u_dut (
    .port_clk       (clk),
    .port_rst_n     (rst_n),
    .port_dwc_ok    (dwc_ok),
    .port_valid     (valid),
    .port_clear     (clear),
    .port_stall     (stall),
    .port_replay    (replay),
    .port_fault     (fault),
    .port_syndrome  (syndrome),
    .port_err_count (err_count)
  );

  dwc_recovery_ctrl #(.CNT_W(2)) u_sat (
    .port_clk       (clk),
    .port_rst_n     (rst_n),
    .port_dwc_ok    (dwc_ok),
    .port_valid     (valid),
    .port_clear     (clear),
    .port_stall     (s_stall),
    .port_replay    (s_replay),
    .port_fault     (s_fault),
    .port_syndrome  (s_syndrome),
    .port_err_count (s_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fault = 0; m_wait = 0; m_cd = 0; m_att = 0; m_cnt = 0; m_w = 0; m_syn = '0;
  endtask

  task automatic model_edge(input logic v, input logic [NCH-1:0] ok, input logic clr);
    bit mm;
    mm = v && (ok != {NCH{1'b1}});
    if (m_fault) begin
      if (clr) begin m_fault = 0; m_cnt = 0; m_syn = '0; end
    end else if (m_cd > 0) begin
      if (clr) begin m_cnt = 0; m_syn = '0; end
      m_cd--;
      if (m_cd == 0) begin m_wait = 1; m_w = 0; end
    end else begin
      if (clr) begin m_cnt = 0; m_syn = '0; end
      if (mm) begin
        m_cnt++;
        m_syn |= ~ok;
        if (m_wait && m_att == MAXR) begin
          m_fault = 1; m_wait = 0;
        end else begin
          m_att  = m_wait ? m_att + 1 : 1;
          m_cd   = 2;
          m_wait = 0;
        end
      end else if (m_wait && v) begin
        m_wait = 0; m_att = 0;
      end
`ifdef DWC_TIMEOUT_EN
      else if (m_wait) begin
        m_w++;
        if (m_w == TMO) begin m_fault = 1; m_wait = 0; m_syn = '1; end
      end
`endif
    end
  endtask

  task automatic check_all(input string ctx);
    int c8, c2;
    c8 = (m_cnt > 255) ? 255 : m_cnt;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    chk({ctx, ".stall"},    32'(stall),      32'(m_fault || m_cd > 0 || m_wait));
    chk({ctx, ".replay"},   32'(replay),     32'(m_cd == 1));
    chk({ctx, ".fault"},    32'(fault),      32'(m_fault));
    chk({ctx, ".syndrome"}, 32'(syndrome),   32'(m_syn));
    chk({ctx, ".err_count"},32'(err_count),  32'(c8));
    chk({ctx, ".sat_count"},32'(s_err_count),32'(c2));
    chk({ctx, ".sat_stall"},32'(s_stall),    32'(m_fault || m_cd > 0 || m_wait));
  endtask

  // Drive at negedge, let the edge happen, then check at the next negedge.
  task automatic step(input string ctx, input logic v, input logic [NCH-1:0] ok, input logic clr);
    valid = v; dwc_ok = ok; clear = clr;
    @(posedge clk);
    model_edge(v, ok, clr);
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic recover_once(input string ctx, input logic [NCH-1:0] bad);
    step(ctx, 1'b1, bad, 1'b0);
    step(ctx, 1'b0, '1, 1'b0);
    step(ctx, 1'b0, '1, 1'b0);
    step(ctx, 1'b1, '1, 1'b0);
  endtask

  initial begin
    int rep_cnt, fault_at, n;
    logic [NCH-1:0] r_ok;
    logic r_v, r_c;

    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (4) step("idle", 1'b0, '1, 1'b0);

    // Single recovered mismatch: stall for 3 cycles, replay in the middle one.
    step("single.mm", 1'b1, 4'b1011, 1'b0);
    chk("single.stall_n1", 32'(stall), 32'd1);
    step("single.rep", 1'b0, '1, 1'b0);
    chk("single.replay_n2", 32'(replay), 32'd1);
    step("single.chk", 1'b0, '1, 1'b0);
    chk("single.stall_n3", 32'(stall), 32'd1);
    step("single.ok", 1'b1, 4'b1111, 1'b0);
    chk("single.run", 32'(stall), 32'd0);
    chk("single.count", 32'(err_count), 32'd1);
    chk("single.syndrome", 32'(syndrome), 32'h4);
    chk("single.fault", 32'(fault), 32'd0);

    // Mismatch pattern on the lines while valid is low must be ignored.
    for (int i = 0; i < 20; i++) step("novalid", 1'b0, 4'b0000, 1'b0);
    chk("novalid.count", 32'(err_count), 32'd1);

    // Persistent mismatch: three replays then fault 10 cycles after the first.
    step("persist.clr", 1'b0, '1, 1'b1);
    step("persist.mm", 1'b1, 4'b1110, 1'b0);
    rep_cnt = 0; fault_at = -1; n = 1;
    while (fault_at < 0 && n < 40) begin
      step("persist", 1'b1, 4'b1110, 1'b0);
      n++;
      if (replay) rep_cnt++;
      if (fault) fault_at = n;
    end
    chk("persist.fault_cycle", 32'(fault_at), 32'(3 * MAXR + 1));
    chk("persist.replays", 32'(rep_cnt), 32'(MAXR));
    chk("persist.count", 32'(err_count), 32'd4);
    chk("persist.syndrome", 32'(syndrome), 32'h1);
    for (int i = 0; i < 3; i++) step("fault.hold", 1'b1, 4'b0000, 1'b0);
    step("fault.clr", 1'b1, 4'b0000, 1'b1);
    chk("fault.cleared", 32'(fault), 32'd0);
    chk("fault.cnt0", 32'(err_count), 32'd0);

    // Seven recovered mismatches: 2-bit counter pins at 3.
    for (int i = 0; i < 7; i++) recover_once("sat", NCH'(1 << (i % NCH)) ^ '1);
    chk("sat.count7", 32'(err_count), 32'd7);
    chk("sat.stuck", 32'(s_err_count), 32'd3);

    // Clear together with a mismatch: clear first, then count the new one.
    step("clrmm", 1'b1, 4'b0110, 1'b1);
    chk("clrmm.count", 32'(err_count), 32'd1);
    chk("clrmm.syndrome", 32'(syndrome), 32'h9);
    chk("clrmm.stall", 32'(stall), 32'd1);
    step("clrmm.rep", 1'b0, '1, 1'b0);
    chk("clrmm.replay", 32'(replay), 32'd1);
    step("clrmm.chk", 1'b0, '1, 1'b0);
    step("clrmm.ok", 1'b1, '1, 1'b0);

    // Watchdog on a withheld recheck.
    step("wd.mm", 1'b1, 4'b0111, 1'b0);
    for (int i = 0; i < 2 + TMO + 3; i++) step("wd.wait", 1'b0, '1, 1'b0);
`ifdef DWC_TIMEOUT_EN
    chk("wd.fault", 32'(fault), 32'd1);
    chk("wd.syndrome", 32'(syndrome), 32'hF);
`else
    chk("wd.nofault", 32'(fault), 32'd0);
    chk("wd.waiting", 32'(stall), 32'd1);
`endif
    step("wd.exit", 1'b1, '1, 1'b1);
    step("wd.exit2", 1'b1, '1, 1'b0);

    // Asynchronous reset in the replay cycle.
    step("rst.mm", 1'b1, 4'b1101, 1'b0);
    step("rst.rep", 1'b0, '1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.replay", 32'(replay), 32'd0);
    chk("rst.all", 32'({fault, syndrome, err_count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("rst.after", 1'b0, '1, 1'b0);

    // Random traffic, biased toward agreeing copies.
    for (int i = 0; i < 400; i++) begin
      r_v  = ($urandom_range(0, 3) != 0);
      r_ok = ($urandom_range(0, 9) < 6) ? '1 : NCH'($urandom);
      r_c  = ($urandom_range(0, 39) == 0);
      step("rand", r_v, r_ok, r_c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
